// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style multiply/divide unit with HI/LO result
// registers. One result bit is produced per cycle, so the control path
// talks to it through start/busy/done.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   start        request, accepted only while idle
//   op           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   rs_data      multiplicand / dividend
//   rt_data      multiplier / divisor
//   busy         high whenever the unit is not idle
//   done         one-cycle pulse in the cycle after hi/lo are written
//   hi, lo       product upper/lower half, or remainder/quotient
//   div_by_zero  last completed op was a divide by zero
//
// Build option: define MULDIV_SIGNED_EN to honour op[0] (MULT/DIV signed).
// Without it every op is unsigned and the sign logic is absent; latency
// does not change.

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    // acc_hi/acc_lo: partial product (mul) or remainder/quotient (div).
    logic [WIDTH-1:0] acc_hi, acc_lo;
    // opnd: the operand held constant through the iterations
    // (multiplicand magnitude, or divisor magnitude).
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] rs_lat;
    logic             is_div;
    logic             div0;

    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [WIDTH-1:0] res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
    logic rs_neg, rt_neg;
    logic neg_res;   // product / quotient must be negated
    logic neg_rem;   // remainder follows the dividend sign

    assign rs_neg = op[0] & rs_data[WIDTH-1];
    assign rt_neg = op[0] & rt_data[WIDTH-1];
    assign rs_mag = rs_neg ? -rs_data : rs_data;
    assign rt_mag = rt_neg ? -rt_data : rt_data;
`else
    logic unused_op0;
    assign unused_op0 = op[0];
    assign rs_mag = rs_data;
    assign rt_mag = rt_data;
`endif

    assign busy = (state != IDLE);

    // ---- FSM ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == CNT_LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- one iteration step ----
    // Shift-add multiply: add the multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the whole pair right.
    logic [WIDTH:0]   mul_sum;
    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. The remainder stays below the divisor,
    // so the difference always fits in WIDTH bits.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;

    // ---- final correction applied in FIX ----
    always_comb begin
        res_hi = acc_hi;
        res_lo = acc_lo;
`ifdef MULDIV_SIGNED_EN
        if (is_div) begin
            if (neg_res) res_lo = -acc_lo;
            if (neg_rem) res_hi = -acc_hi;
        end else if (neg_res) begin
            {res_hi, res_lo} = -{acc_hi, acc_lo};
        end
`endif
        // Divide by zero: fixed quotient pattern, dividend passed through.
        if (div0) begin
            res_hi = rs_lat;
            res_lo = '1;
        end
    end

    // ---- datapath ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opnd        <= '0;
            rs_lat      <= '0;
            is_div      <= 1'b0;
            div0        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
`endif
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        acc_hi <= '0;
                        rs_lat <= rs_data;
                        is_div <= op[1];
                        div0   <= op[1] && (rt_data == '0);
                        if (op[1]) begin
                            acc_lo <= rs_mag;
                            opnd   <= rt_mag;
                        end else begin
                            acc_lo <= rt_mag;
                            opnd   <= rs_mag;
                        end
`ifdef MULDIV_SIGNED_EN
                        neg_res <= rs_neg ^ rt_neg;
                        neg_rem <= rs_neg;
`endif
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    hi          <= res_hi;
                    lo          <= res_lo;
                    div_by_zero <= div0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic          clk, rst, start;
    logic [1:0]    op;
    logic [W-1:0]  rs_data, rt_data;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           e0;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural rules.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        logic   sgn;
        longint sa, sb_, q, r, p;
        logic [63:0] up;
`ifdef MULDIV_SIGNED_EN
        sgn = o[0];
`else
        sgn = 1'b0;
`endif
        e.dz = 1'b0;
        e.e0 = 0;
        if (!o[1]) begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb_ = longint'($signed(b));
                p = sa * sb_;
                up = p;
            end else begin
                up = {32'b0, a} * {32'b0, b};
            end
            e.hi = up[63:32];
            e.lo = up[31:0];
        end else if (b == 0) begin
            e.hi = a;
            e.lo = '1;
            e.dz = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb_ = longint'($signed(b));
            q = sa / sb_;   // truncates toward zero
            r = sa % sb_;   // sign of dividend
            e.lo = q[31:0];
            e.hi = r[31:0];
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return 32'd1;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Call at a negedge. Waits for idle (done cycle counts as idle), issues one
    // op for one cycle, then scrambles the inputs to show they were latched.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_wait_timeout", 64'(busy), 64'd0);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        e = model(o, a, b);
        e.e0 = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
        chk("busy_after_accept", 64'(busy), 64'd1);
        chk("done_low_after_accept", 64'(done), 64'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
                chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
                chk("latency", 64'(cyc - e.e0), 64'(LAT));
                chk("busy_in_done_cycle", 64'(busy), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_dz", 64'(div_by_zero), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(2'b00, 32'd7, 32'd6);
        issue(2'b01, 32'hFFFF_FFFD, 32'd5);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2);
        issue(2'b10, 32'd100, 32'd0);
        issue(2'b00, 32'd1, 32'd1);              // clears div_by_zero
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'b11, 32'd55, 32'd0);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000);

        // start held for three cycles: one op only
        n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        op = 2'b00; rs_data = 32'd3; rt_data = 32'd3; start = 1'b1;
        begin
            exp_t e;
            e = model(2'b00, 32'd3, 32'd3);
            e.e0 = cyc + 1;
            sb.push_back(e);
        end
        repeat (3) @(negedge clk);
        start = 1'b0;
        // Issued while busy: lands in the done cycle of the 3x3 op.
        issue(2'b00, 32'd2, 32'd2);

        // Reset mid-operation: outputs clear, aborted op never completes.
        issue(2'b10, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_dz", 64'(div_by_zero), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (LAT + 5) @(negedge clk);   // monitor flags any stray done

        // Randomized ops
        for (int i = 0; i < 40; i++)
            issue(2'($urandom_range(0, 3)), rand_val(), rand_val());

        n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
